pipeline_hazard_ctrl: RTL

- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline latches, plus the PC write enable.
- Decides from cache hit status, load-use hazards, taken branches/jumps and halt.
- Contains a small FSM (run / data-memory wait / halted) and a stall-cycle performance counter.

---
 rtl/pipeline_hazard_ctrl_if.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the 5-stage pipeline datapath and its hazard controller.
//   master : pipeline side; drives hazard status, receives latch controls.
//   slave  : controller side; samples hazard status, drives latch controls.
// Status    : ihit, dhit, mem_dren, mem_dwen, ex_load, ex_rt, id_rs, id_rt,
//             ex_redirect, wb_halt
// Controls  : pc_en, ifid/idex/exmem/memwb _en and _flush
interface pipeline_hazard_ctrl_if;
  logic       ihit;
  logic       dhit;
  logic       mem_dren;
  logic       mem_dwen;
  logic       ex_load;
  logic [4:0] ex_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       ex_redirect;
  logic       wb_halt;

  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic       memwb_flush;

  modport master (
    output ihit, dhit, mem_dren, mem_dwen, ex_load, ex_rt, id_rs, id_rt,
           ex_redirect, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush
  );

  modport slave (
    input  ihit, dhit, mem_dren, mem_dwen, ex_load, ex_rt, id_rs, id_rt,
           ex_redirect, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline.
// Generates PC write enable and per-latch enable/flush from cache hit status,
// load-use hazards, EX-stage redirects and halt. Tracks an outstanding data
// access (DWAIT) and a terminal HALT state, and counts stalled cycles.
// Ports:
//   CLK        clock
//   nRST       asynchronous active-low reset
//   hz         pipeline_hazard_ctrl_if.slave (hazard status in, latch controls out)
//   halted     sticky halt indication
//   stall_cnt  saturating count of cycles with pc_en=0 outside HALT
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  pipeline_hazard_ctrl_if.slave hz,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic access;
  logic mem_block;
  logic load_use;

  logic pc_en_w;
  logic ifid_en_w, idex_en_w, exmem_en_w, memwb_en_w;
  logic ifid_fl_w, idex_fl_w, exmem_fl_w, memwb_fl_w;

  assign access    = hz.mem_dren | hz.mem_dwen;
  // The MEM stage is blocked while a miss is outstanding, whether it began
  // this cycle (RUN) or earlier (DWAIT).
  assign mem_block = !hz.dhit && ((state == DWAIT) || access);
  assign load_use  = hz.ex_load && (hz.ex_rt != 5'd0) &&
                     ((hz.ex_rt == hz.id_rs) || (hz.ex_rt == hz.id_rt));

  // State register
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (hz.wb_halt) begin
      state_nxt = HALT;
    end else begin
      unique case (state)
        RUN:     if (access && !hz.dhit) state_nxt = DWAIT;
        DWAIT:   if (hz.dhit)            state_nxt = RUN;
        HALT:                            state_nxt = HALT;
        default:                         state_nxt = RUN;
      endcase
    end
  end

  // Output logic
  always_comb begin
    pc_en_w    = 1'b0;
    ifid_en_w  = 1'b0;
    idex_en_w  = 1'b0;
    exmem_en_w = 1'b0;
    memwb_en_w = 1'b0;
    ifid_fl_w  = 1'b0;
    idex_fl_w  = 1'b0;
    exmem_fl_w = 1'b0;
    memwb_fl_w = 1'b0;
    halted     = 1'b0;

    if (!nRST) begin
      // everything quiet while in reset
    end else if (state == HALT) begin
      halted = 1'b1;
    end else if (mem_block) begin
      // Freeze the front of the pipe; WB receives a bubble so the stalled
      // MEM instruction is not written back twice.
      memwb_en_w = 1'b1;
      memwb_fl_w = 1'b1;
    end else begin
      pc_en_w    = 1'b1;
      ifid_en_w  = 1'b1;
      idex_en_w  = 1'b1;
      exmem_en_w = 1'b1;
      memwb_en_w = 1'b1;
      if (hz.ex_redirect) begin
        // Redirect squashes both younger instructions and always loads the
        // new PC, so neither a load-use nor an I-miss can hold it back.
        ifid_fl_w = 1'b1;
        idex_fl_w = 1'b1;
      end else if (load_use) begin
        // Hold IF/ID (even on an I-miss) and insert one bubble into EX.
        pc_en_w   = 1'b0;
        ifid_en_w = 1'b0;
        idex_fl_w = 1'b1;
      end else if (!hz.ihit) begin
        pc_en_w   = 1'b0;
        ifid_fl_w = 1'b1;
      end
    end
  end

  assign hz.pc_en       = pc_en_w;
  assign hz.ifid_en     = ifid_en_w;
  assign hz.idex_en     = idex_en_w;
  assign hz.exmem_en    = exmem_en_w;
  assign hz.memwb_en    = memwb_en_w;
  assign hz.ifid_flush  = ifid_fl_w;
  assign hz.idex_flush  = idex_fl_w;
  assign hz.exmem_flush = exmem_fl_w;
  assign hz.memwb_flush = memwb_fl_w;

  // Stall-cycle counter, saturating at all-ones
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if ((state != HALT) && !pc_en_w && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
